// File: rtl/trace_checker.sv
// trace_checker: compares a CPU's retired-instruction stream against a golden
// expected trace. Commits are buffered in a small FIFO, and each buffered
// commit is compared with the next expected record.
//
// Ports:
//   i_clock, i_resetn                  clock, async active-low reset
//   i_start                            clear results and begin a check run
//   i_commit{Valid,PC,RdAddr,RdData}   retired instruction (no backpressure)
//   i_exp{Valid,PC,RdAddr,RdData,Last} golden record stream
//   o_expReady                         golden record consumed this cycle (comb)
//   o_state                            00 IDLE, 01 RUN, 10 PASS, 11 FAIL
//   o_matchCount, o_errCount           saturating compare counters
//   o_errPC, o_errGotData, o_errExpData first-mismatch capture
//   o_overflow                         sticky: commit dropped on full buffer
module trace_checker #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_start,
  input  logic        i_commitValid,
  input  logic [31:0] i_commitPC,
  input  logic [4:0]  i_commitRdAddr,
  input  logic [31:0] i_commitRdData,
  input  logic        i_expValid,
  input  logic [31:0] i_expPC,
  input  logic [4:0]  i_expRdAddr,
  input  logic [31:0] i_expRdData,
  input  logic        i_expLast,
  output logic        o_expReady,
  output logic [1:0]  o_state,
  output logic [31:0] o_matchCount,
  output logic [31:0] o_errCount,
  output logic [31:0] o_errPC,
  output logic [31:0] o_errGotData,
  output logic [31:0] o_errExpData,
  output logic        o_overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PASS = 2'b10,
    S_FAIL = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } commit_t;

  state_t        state;
  commit_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  commit_t       head;
  commit_t       push_rec;
  logic          in_run;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          is_match;
  logic          go_pass;
  logic          go_fail;
  logic [31:0]   got_data_m;
  logic [31:0]   exp_data_m;
  logic [31:0]   match_next;
  logic [31:0]   err_next;

  // Handshake, FIFO control and compare of the FIFO head with the golden record
  always_comb begin
    in_run     = (state == S_RUN);
    empty      = (count == CW'(0));
    full       = (count == CW'(FIFO_DEPTH));
    pop        = in_run & ~empty & i_expValid;
    push       = in_run & i_commitValid & (~full | pop);
    drop       = in_run & i_commitValid & full & ~pop;
    head       = mem[rd_ptr];
    push_rec   = '{pc: i_commitPC, rd_addr: i_commitRdAddr, rd_data: i_commitRdData};
    // x0 writes are architecturally discarded, so data is don't-care there
    got_data_m = (head.rd_addr == 5'd0) ? 32'd0 : head.rd_data;
    exp_data_m = (i_expRdAddr == 5'd0) ? 32'd0 : i_expRdData;
    is_match   = (head.pc == i_expPC) && (head.rd_addr == i_expRdAddr) &&
                 (got_data_m == exp_data_m);
    match_next = o_matchCount;
    err_next   = o_errCount;
    if (pop && is_match && (o_matchCount != 32'hFFFF_FFFF)) match_next = o_matchCount + 32'd1;
    if (pop && !is_match && (o_errCount != 32'hFFFF_FFFF)) err_next = o_errCount + 32'd1;
    go_pass = pop & i_expLast & (err_next == 32'd0) & ~drop;
    go_fail = drop | (pop & ~is_match & STOP_ON_ERR) |
              (pop & i_expLast & (err_next != 32'd0));
  end

  assign o_expReady = pop;
  assign o_state    = state;

  // Buffer storage; contents need no reset since occupancy gates every read
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  // Run-state machine, FIFO pointers and result registers
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_matchCount <= '0;
      o_errCount   <= '0;
      o_errPC      <= '0;
      o_errGotData <= '0;
      o_errExpData <= '0;
      o_overflow   <= 1'b0;
    end else if (i_start) begin
      state        <= S_RUN;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_matchCount <= '0;
      o_errCount   <= '0;
      o_errPC      <= '0;
      o_errGotData <= '0;
      o_errExpData <= '0;
      o_overflow   <= 1'b0;
    end else if (in_run) begin
      o_matchCount <= match_next;
      o_errCount   <= err_next;
      if (pop && !is_match && (o_errCount == 32'd0)) begin
        o_errPC      <= head.pc;
        o_errGotData <= got_data_m;
        o_errExpData <= exp_data_m;
      end
      if (drop) o_overflow <= 1'b1;
      if (go_pass || go_fail) begin
        // Run is over: whatever is still buffered is discarded
        state  <= go_pass ? S_PASS : S_FAIL;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, commit-record buffer depth (power of two, >=2).
REQ-002 Parameter STOP_ON_ERR, default 1, 1 = enter FAIL on first mismatch; 0 = keep checking.
REQ-003 i_clock  in  1  clock; all state updates on its rising edge.
REQ-004 i_resetn  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  single-cycle pulse that clears results and begins a check run.
REQ-006 i_commitValid  in  1  CPU retired one instruction this cycle (no backpressure).
REQ-007 i_commitPC / i_commitRdData  in  32 each  retired PC / written value.
REQ-008 i_commitRdAddr  in  5  retired destination register.
REQ-009 i_expValid  in  1  expected-trace record available.
REQ-010 i_expPC / i_expRdData  in  32 each  golden PC / value.
REQ-011 i_expRdAddr  in  5  golden destination register.
REQ-012 i_expLast  in  1  qualifies the final golden record.
REQ-013 o_expReady  out  1  expected record consumed this cycle.
REQ-014 o_state  out  2  00 IDLE, 01 RUN, 10 PASS, 11 FAIL.
REQ-015 o_matchCount / o_errCount  out  32 each  compared-equal / compared-unequal records.
REQ-016 o_errPC, o_errGotData, o_errExpData  out  32 each  first mismatch capture.
REQ-017 o_overflow  out  1  sticky: commit dropped because buffer was full.

Function
REQ-018 FSM: IDLE -i_start-> RUN; RUN -> PASS or FAIL per REQ-026..REQ-028; PASS/FAIL -i_start-> RUN; no other transitions.
REQ-019 i_start in any state clears counters, capture registers, o_overflow and the buffer in the same edge it enters RUN.
REQ-020 Commit push: in RUN, i_commitValid pushes {PC, rdAddr, rdData} into the FIFO; commits are ignored in IDLE/PASS/FAIL.
REQ-021 o_expReady = (state==RUN) & FIFO non-empty & i_expValid, combinational; handshake occurs when o_expReady=1.
REQ-022 On handshake, FIFO head pops and is compared with the expected record on the same edge; results visible the following cycle.
REQ-023 Match rule: PCs equal, rdAddr equal, and data equal, where data of both sides is treated as 0x00000000 when the respective rdAddr==0.
REQ-024 Match -> o_matchCount+1; mismatch -> o_errCount+1; both counters saturate at 0xFFFFFFFF.
REQ-025 First mismatch only (o_errCount was 0): capture o_errPC=commit PC, o_errGotData=commit data (masked per REQ-023), o_errExpData=expected data (masked).
REQ-026 Mismatch with STOP_ON_ERR=1 -> FAIL on that edge.
REQ-027 Handshake with i_expLast=1 -> PASS if error count after this compare is 0, else FAIL; remaining FIFO contents are discarded.
REQ-028 Push while FIFO full and no pop same cycle -> record dropped, o_overflow=1, state -> FAIL.
REQ-029 Push and pop in same cycle on full FIFO is legal: occupancy unchanged, no overflow.
REQ-030 Push and pop in same cycle on empty FIFO: no pop occurs (o_expReady=0); push lands normally.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter ranges 0..FIFO_DEPTH.
REQ-032 In PASS/FAIL all outputs hold until i_start or reset.

Reset
REQ-033 i_resetn low asynchronously forces o_state=IDLE, o_expReady=0, all counters/capture registers=0, o_overflow=0, FIFO empty.
REQ-034 Reset asserted mid-run discards all buffered records; no compare completes on that edge.
REQ-035 After deassertion the block stays IDLE until i_start.

Verification
REQ-036 Reset, start, 3 commits (PC 0x0/0x4/0x8, x1..x3=5,7,9) matching golden with last on 3rd -> o_matchCount=3, o_errCount=0, o_state=PASS.
REQ-037 Commit x0 data 0x1234 vs golden x0 data 0x0 -> counted as match.
REQ-038 2nd record golden data 0x8 vs got 0x7, STOP_ON_ERR=1 -> FAIL next cycle, o_errPC=0x4, o_errGotData=0x7, o_errExpData=0x8, o_matchCount=1.
REQ-039 i_expValid held low, 5 commits with FIFO_DEPTH=4 -> 5th dropped, o_overflow=1, FAIL.
REQ-040 STOP_ON_ERR=0, 4 records with mismatches at 2 and 4, last on 4 -> o_errCount=2, capture holds record 2, FAIL.
REQ-041 Assert i_resetn low with 2 records buffered in RUN -> all outputs zero/IDLE immediately; i_start then fresh 1-record match -> PASS, o_matchCount=1.
